// File: rtl/io_bus_if.sv
// io_bus_if: CPU data-port bus between the CPU bus mux and the I/O bridge.
//   addr  : byte address of the current access (word aligned, [1:0] unused)
//   we    : single-cycle store strobe
//   wdata : store data
//   rdata : load data returned by the peripheral (combinational)
//   sel   : peripheral claims the address; the CPU bus mux uses it
// Modports: master = CPU side, slave = peripheral side.
interface io_bus_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;

  modport master (output addr, output we, output wdata, input rdata, input sel);
  modport slave  (input addr, input we, input wdata, output rdata, output sel);
endinterface

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: memory-mapped I/O bridge between the CPU data port and the
// board peripherals.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : CPU bus (slave side): addr/we/wdata in, rdata/sel out
//   sw       : raw switches, asynchronous; read back debounced at +0x70
//   btn      : raw buttons, asynchronous, active-high; debounced at +0x78
//   led      : LED register, written at +0x60
//   dig_din  : hex display data, registered copy of the last store to +0x00
//   dig_we   : hex display load pulse, one cycle after each store to +0x00
// Button rising edges (after debouncing) latch into a sticky event register
// at +0x7C, cleared by writing 1s.
module io_bus_bridge #(
  parameter logic [31:0] IO_BASE    = 32'hFFFF_F000,
  parameter int          DEB_CYCLES = 100000,
  parameter int          CNT_W      = 17
) (
  input  logic        clk,
  input  logic        rst,
  io_bus_if.slave     bus,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [31:0] dig_din,
  output logic        dig_we
);

  // Switches occupy bits [23:0], buttons bits [28:24] of the conditioned vector.
  localparam int NIN = 29;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  // Word offsets (addr[7:2]) of the mapped registers.
  localparam logic [5:0] OFF_DIG = 6'h00;
  localparam logic [5:0] OFF_LED = 6'h18;
  localparam logic [5:0] OFF_SW  = 6'h1C;
  localparam logic [5:0] OFF_BTN = 6'h1E;
  localparam logic [5:0] OFF_EVT = 6'h1F;

  logic             sel_s;
  logic [5:0]       off_s;
  logic             wr_dig_s;
  logic             wr_led_s;
  logic             wr_evt_s;
  logic [31:0]      rdata_s;

  logic [NIN-1:0]   raw_s;
  logic [NIN-1:0]   sync1_r;
  logic [NIN-1:0]   sync2_r;
  logic [NIN-1:0]   deb_r;
  logic [NIN-1:0]   deb_nxt_s;
  logic [CNT_W-1:0] cnt_r     [NIN];
  logic [CNT_W-1:0] cnt_nxt_s [NIN];

  logic [4:0]       btn_rise_s;
  logic [4:0]       evt_clr_s;
  logic [4:0]       evt_r;
  logic [4:0]       evt_nxt_s;

  logic [23:0]      led_r;
  logic [31:0]      dig_din_r;
  logic             dig_we_r;

  assign raw_s    = {btn, sw};
  assign sel_s    = (bus.addr[31:8] == IO_BASE[31:8]);
  assign off_s    = bus.addr[7:2];
  assign wr_dig_s = bus.we & sel_s & (off_s == OFF_DIG);
  assign wr_led_s = bus.we & sel_s & (off_s == OFF_LED);
  assign wr_evt_s = bus.we & sel_s & (off_s == OFF_EVT);

  assign bus.sel   = sel_s;
  assign bus.rdata = rdata_s;
  assign led       = led_r;
  assign dig_din   = dig_din_r;
  assign dig_we    = dig_we_r;

  // Per-bit debounce: count consecutive cycles the synchronized input
  // disagrees with the debounced value; adopt it once the run is long enough.
  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      deb_nxt_s[i] = deb_r[i];
      cnt_nxt_s[i] = CNT_ZERO;
      if (sync2_r[i] == deb_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == DEB_LAST) begin
        deb_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i] = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Synchronizers, debounced values and debounce counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {NIN{1'b0}};
      sync2_r <= {NIN{1'b0}};
      deb_r   <= {NIN{1'b0}};
      for (int i = 0; i < NIN; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_r   <= deb_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Event update: a rise in the same cycle as a W1C clear keeps the bit set,
  // so the rise is OR-ed in after the clear mask is applied.
  always_comb begin
    btn_rise_s = deb_nxt_s[28:24] & ~deb_r[28:24];
    if (wr_evt_s) begin
      evt_clr_s = bus.wdata[4:0];
    end else begin
      evt_clr_s = 5'b00000;
    end
    evt_nxt_s = (evt_r & ~evt_clr_s) | btn_rise_s;
  end

  // Store-side registers: LED, display write port and event register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r     <= 24'h000000;
      dig_din_r <= 32'h0000_0000;
      dig_we_r  <= 1'b0;
      evt_r     <= 5'b00000;
    end else begin
      dig_we_r <= wr_dig_s;
      evt_r    <= evt_nxt_s;
      if (wr_dig_s) begin
        dig_din_r <= bus.wdata;
      end
      if (wr_led_s) begin
        led_r <= bus.wdata[23:0];
      end
    end
  end

  // Load mux; anything not mapped (or outside the window) reads as zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (sel_s) begin
      case (off_s)
        OFF_DIG: rdata_s = dig_din_r;
        OFF_LED: rdata_s = {8'h00, led_r};
        OFF_SW:  rdata_s = {8'h00, deb_r[23:0]};
        OFF_BTN: rdata_s = {27'h0000000, deb_r[28:24]};
        OFF_EVT: rdata_s = {27'h0000000, evt_r};
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
// tb_io_bus_bridge: directed scenarios plus randomized traffic for
// io_bus_bridge, checked every cycle against a behavioural model.
module tb_io_bus_bridge;

  localparam logic [31:0] IO_BASE = 32'hFFFF_F000;
  localparam int          DEB     = 4;

  logic        clk;
  logic        rst;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [23:0] led;
  logic [31:0] dig_din;
  logic        dig_we;

  int n_checks = 0;
  int n_errors = 0;

  io_bus_if bus_if();

  io_bus_bridge #(
    .IO_BASE   (IO_BASE),
    .DEB_CYCLES(DEB),
    .CNT_W     (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .sw     (sw),
    .btn    (btn),
    .led    (led),
    .dig_din(dig_din),
    .dig_we (dig_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state. hist[k] is the raw {btn,sw} sampled k edges ago;
  // a debounced bit follows the raw value once the samples taken 2..DEB+1
  // edges ago all agree on it.
  logic [28:0] hist [DEB+2];
  logic [28:0] deb_m;
  logic [4:0]  evt_m;
  logic [23:0] led_m;
  logic [31:0] dig_m;
  logic        dig_we_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEB + 2; k++) hist[k] = 29'h0;
    deb_m    = 29'h0;
    evt_m    = 5'h0;
    led_m    = 24'h0;
    dig_m    = 32'h0;
    dig_we_m = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [7:0] off;
    off = a[7:0] & 8'hFC;
    if (a[31:8] != IO_BASE[31:8]) return 32'h0;
    case (off)
      8'h00:   return dig_m;
      8'h60:   return {8'h0, led_m};
      8'h70:   return {8'h0, deb_m[23:0]};
      8'h78:   return {27'h0, deb_m[28:24]};
      8'h7C:   return {27'h0, evt_m};
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model over one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [28:0] all_hi;
    logic [28:0] all_lo;
    logic [28:0] deb_new;
    logic [4:0]  rise;
    logic        wr;
    logic [7:0]  off;
    for (int k = DEB + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {btn, sw};
    all_hi = 29'h1FFF_FFFF;
    all_lo = 29'h1FFF_FFFF;
    for (int k = 2; k < DEB + 2; k++) begin
      all_hi = all_hi & hist[k];
      all_lo = all_lo & ~hist[k];
    end
    deb_new = (deb_m | all_hi) & ~all_lo;
    rise    = deb_new[28:24] & ~deb_m[28:24];
    deb_m   = deb_new;
    wr  = bus_if.we && (bus_if.addr[31:8] == IO_BASE[31:8]);
    off = bus_if.addr[7:0] & 8'hFC;
    dig_we_m = wr && (off == 8'h00);
    if (dig_we_m) dig_m = bus_if.wdata;
    if (wr && off == 8'h60) led_m = bus_if.wdata[23:0];
    if (wr && off == 8'h7C) evt_m = evt_m & ~bus_if.wdata[4:0];
    evt_m = evt_m | rise;
  endtask

  // One clock: update model, wait past the edge, compare all observables.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_val("sel", 32'(bus_if.sel), 32'(bus_if.addr[31:8] == IO_BASE[31:8]));
    check_val("rdata", bus_if.rdata, exp_read(bus_if.addr));
    check_val("led", 32'(led), 32'(led_m));
    check_val("dig_din", dig_din, dig_m);
    check_val("dig_we", 32'(dig_we), 32'(dig_we_m));
    bus_if.we = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.we    = 1'b1;
    step();
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 8))
      0:       a = IO_BASE + 32'h00;
      1:       a = IO_BASE + 32'h04;
      2:       a = IO_BASE + 32'h60;
      3:       a = IO_BASE + 32'h70;
      4:       a = IO_BASE + 32'h78;
      5:       a = IO_BASE + 32'h7C;
      6:       a = IO_BASE + 32'h40;
      7:       a = 32'h0000_1000;
      default: a = IO_BASE + 32'h100;
    endcase
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  int n;

  initial begin
    rst          = 1'b1;
    sw           = 24'h0;
    btn          = 5'h0;
    bus_if.addr  = IO_BASE;
    bus_if.we    = 1'b0;
    bus_if.wdata = 32'h0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_led", 32'(led), 32'h0);
    check_val("rst_dig_din", dig_din, 32'h0);
    check_val("rst_dig_we", 32'(dig_we), 32'h0);
    bus_if.addr = IO_BASE + 32'h7C;
    #1;
    check_val("rst_evt", bus_if.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single display store, one-cycle pulse, readback
    store(IO_BASE, 32'h1234_ABCD);
    check_val("t1_we", 32'(dig_we), 32'h1);
    check_val("t1_din", dig_din, 32'h1234_ABCD);
    step();
    check_val("t1_we_off", 32'(dig_we), 32'h0);
    check_val("t1_read", bus_if.rdata, 32'h1234_ABCD);

    // 2: back-to-back stores, then a store to an unmapped offset
    store(IO_BASE, 32'h1);
    check_val("t2_we0", 32'(dig_we), 32'h1);
    check_val("t2_din0", dig_din, 32'h1);
    store(IO_BASE, 32'h2);
    check_val("t2_we1", 32'(dig_we), 32'h1);
    check_val("t2_din1", dig_din, 32'h2);
    store(IO_BASE + 32'h04, 32'hDEAD_BEEF);
    check_val("t2_unmapped_we", 32'(dig_we), 32'h0);
    check_val("t2_unmapped_rd", bus_if.rdata, 32'h0);

    // 3: switch latency and short glitch rejection
    bus_if.addr = IO_BASE + 32'h70;
    sw = 24'h00A5A5;
    n = 0;
    while (n < 12) begin
      step();
      n++;
      if (bus_if.rdata == 32'h0000_A5A5) break;
    end
    check_val("t3_latency", 32'(n), 32'(DEB + 2));
    sw = 24'h00A5A4;
    repeat (3) step();
    sw = 24'h00A5A5;
    for (int i = 0; i < 8; i++) begin
      step();
      check_val("t3_glitch", bus_if.rdata, 32'h0000_A5A5);
    end

    // 4: button press, sticky event, release, W1C clear
    bus_if.addr = IO_BASE + 32'h78;
    btn = 5'h04;
    repeat (DEB + 1) step();
    check_val("t4_btn_early", bus_if.rdata, 32'h0);
    step();
    check_val("t4_btn", bus_if.rdata, 32'h4);
    bus_if.addr = IO_BASE + 32'h7C;
    #1;
    check_val("t4_evt", bus_if.rdata, 32'h4);
    btn = 5'h00;
    repeat (DEB + 2) step();
    check_val("t4_evt_hold", bus_if.rdata, 32'h4);
    bus_if.addr = IO_BASE + 32'h78;
    #1;
    check_val("t4_btn_rel", bus_if.rdata, 32'h0);
    store(IO_BASE + 32'h7C, 32'h4);
    check_val("t4_evt_clr", bus_if.rdata, 32'h0);

    // 5: clear on the same edge as a rise keeps the bit
    btn = 5'h04;
    repeat (DEB + 1) step();
    store(IO_BASE + 32'h7C, 32'h4);
    check_val("t5_evt_set_wins", bus_if.rdata, 32'h4);
    btn = 5'h00;
    repeat (DEB + 2) step();

    // 6: asynchronous reset mid-cycle, then an out-of-window access
    store(IO_BASE + 32'h60, 32'h00FF_FFFF);
    check_val("t6_led", 32'(led), 32'h00FF_FFFF);
    bus_if.addr = IO_BASE + 32'h7C;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_val("t6_rst_led", 32'(led), 32'h0);
    check_val("t6_rst_din", dig_din, 32'h0);
    check_val("t6_rst_evt", bus_if.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.addr = 32'h0000_1000;
    #1;
    check_val("t6_sel_out", 32'(bus_if.sel), 32'h0);

    // Randomized traffic with slowly changing raw inputs
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) sw = 24'($urandom);
      if ($urandom_range(0, 5) == 0) btn = 5'($urandom);
      bus_if.addr  = pick_addr();
      bus_if.wdata = $urandom;
      bus_if.we    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
